// File: rtl/lsu_dmem.sv
// Load/store unit: turns MEM-stage loads/stores into a req/ack word bus transaction and extends load data.
// Optional LSU_TIMEOUT_EN compiles in a bus-ack timeout that aborts the access with a fault.
module lsu_dmem #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        lsu_stall,
    output logic        fault,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic        bus_req_q;
    logic        bus_we_q;
    logic        fault_q;
    logic [31:0] bus_addr_q;
    logic [31:0] bus_wdata_q;
    logic [31:0] rdata_q;
    logic [3:0]  bus_be_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;

    logic        access_s;
    logic        f3_ok_s;
    logic        misaligned_s;
    logic        idle_s;
    logic        illegal_s;
    logic        start_s;
    logic [3:0]  be_s;
    logic [31:0] wdata_s;
    logic [7:0]  byte_s;
    logic [15:0] half_s;
    logic [31:0] load_s;

`ifdef LSU_TIMEOUT_EN
    localparam logic [9:0] TO_LAST = 10'(TIMEOUT - 1);
    logic [9:0] cnt_q;
`else
    logic unused_cfg_s;
    assign unused_cfg_s = (TIMEOUT == 32'sd0);
`endif

    // Legality check of the access presented in IDLE; rst gating keeps outputs quiet during reset.
    always_comb begin
        access_s = mem_read | mem_write;
        f3_ok_s  = 1'b0;
        if (mem_write) begin
            case (funct3)
                3'd0, 3'd1, 3'd2: f3_ok_s = 1'b1;
                default:          f3_ok_s = 1'b0;
            endcase
        end else begin
            case (funct3)
                3'd0, 3'd1, 3'd2, 3'd4, 3'd5: f3_ok_s = 1'b1;
                default:                      f3_ok_s = 1'b0;
            endcase
        end
        case (funct3[1:0])
            2'b01:   misaligned_s = addr[0];
            2'b10:   misaligned_s = |addr[1:0];
            default: misaligned_s = 1'b0;
        endcase
        idle_s    = rst & (state_q == S_IDLE) & access_s;
        illegal_s = idle_s & (~f3_ok_s | misaligned_s);
        start_s   = idle_s & f3_ok_s & ~misaligned_s;
    end

    // Byte enables and lane-replicated store data for the access being launched.
    always_comb begin
        be_s    = 4'b1111;
        wdata_s = 32'd0;
        if (mem_write) begin
            case (funct3[1:0])
                2'b00: begin
                    be_s    = 4'b0001 << addr[1:0];
                    wdata_s = {4{wdata[7:0]}};
                end
                2'b01: begin
                    be_s    = 4'b0011 << addr[1:0];
                    wdata_s = {2{wdata[15:0]}};
                end
                default: begin
                    be_s    = 4'b1111;
                    wdata_s = wdata;
                end
            endcase
        end else begin
            be_s    = 4'b1111;
            wdata_s = 32'd0;
        end
    end

    // Lane selection uses the latched byte offset, so address changes during REQ are harmless.
    always_comb begin
        case (off_q)
            2'd0:    byte_s = bus_rdata[7:0];
            2'd1:    byte_s = bus_rdata[15:8];
            2'd2:    byte_s = bus_rdata[23:16];
            default: byte_s = bus_rdata[31:24];
        endcase
        if (off_q[1]) begin
            half_s = bus_rdata[31:16];
        end else begin
            half_s = bus_rdata[15:0];
        end
        case (f3_q)
            3'd0:    load_s = {{24{byte_s[7]}}, byte_s};
            3'd1:    load_s = {{16{half_s[15]}}, half_s};
            3'd4:    load_s = {24'd0, byte_s};
            3'd5:    load_s = {16'd0, half_s};
            default: load_s = bus_rdata;
        endcase
    end

    // Transaction FSM with registered bus and result outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'd0;
            bus_be_q    <= 4'd0;
            bus_wdata_q <= 32'd0;
            rdata_q     <= 32'd0;
            fault_q     <= 1'b0;
            f3_q        <= 3'd0;
            off_q       <= 2'd0;
`ifdef LSU_TIMEOUT_EN
            cnt_q       <= 10'd0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    fault_q <= 1'b0;
                    rdata_q <= 32'd0;
                    if (start_s) begin
                        state_q     <= S_REQ;
                        bus_req_q   <= 1'b1;
                        bus_we_q    <= mem_write;
                        bus_addr_q  <= {addr[31:2], 2'b00};
                        bus_be_q    <= be_s;
                        bus_wdata_q <= wdata_s;
                        f3_q        <= funct3;
                        off_q       <= addr[1:0];
`ifdef LSU_TIMEOUT_EN
                        cnt_q       <= 10'd0;
`endif
                    end
                end
                S_REQ: begin
                    if (bus_ack) begin
                        state_q   <= S_DONE;
                        bus_req_q <= 1'b0;
                        rdata_q   <= bus_we_q ? 32'd0 : load_s;
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (cnt_q == TO_LAST) begin
                        state_q   <= S_DONE;
                        bus_req_q <= 1'b0;
                        fault_q   <= 1'b1;
                        rdata_q   <= 32'd0;
                    end else begin
                        cnt_q <= cnt_q + 10'd1;
                    end
`endif
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    fault_q <= 1'b0;
                    rdata_q <= 32'd0;
                end
                default: begin
                    state_q   <= S_IDLE;
                    bus_req_q <= 1'b0;
                    fault_q   <= 1'b0;
                    rdata_q   <= 32'd0;
                end
            endcase
        end
    end

    assign lsu_stall = start_s | (state_q == S_REQ);
    assign fault     = fault_q | illegal_s;
    assign rdata     = rdata_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_be    = bus_be_q;
    assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_lsu_dmem.sv
// Directed table-driven bench for lsu_dmem; the timeout sequence runs when LSU_TIMEOUT_EN is defined.
module tb_lsu_dmem;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        lsu_stall;
    logic        fault;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = 32'd0;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] brd;
        int          waits;
        logic        bad;
        logic [3:0]  be;
        logic [31:0] bwd;
        logic [31:0] rdata;
    } vec_t;

    vec_t tbl[16];

    lsu_dmem #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .addr(addr), .wdata(wdata), .rdata(rdata),
        .lsu_stall(lsu_stall), .fault(fault), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic run_access(input vec_t v, input int idx);
        int  n_stall;
        int  n_req;
        int  n_fault;
        bit  done;
        mem_read  = v.rd;
        mem_write = v.wr;
        funct3    = v.f3;
        addr      = v.addr;
        wdata     = v.wd;
        if (v.bad) begin
            @(negedge clk);
            chk($sformatf("v%0d_fault", idx), 32'(fault), 32'd1);
            chk($sformatf("v%0d_stall", idx), 32'(lsu_stall), 32'd0);
            chk($sformatf("v%0d_req", idx), 32'(bus_req), 32'd0);
            chk($sformatf("v%0d_rdata", idx), rdata, 32'd0);
            next_cycle();
            mem_read  = 1'b0;
            mem_write = 1'b0;
            @(negedge clk);
            chk($sformatf("v%0d_fault_pulse", idx), 32'(fault), 32'd0);
            chk($sformatf("v%0d_req_after", idx), 32'(bus_req), 32'd0);
            next_cycle();
        end else begin
            n_stall = 0;
            n_req   = 0;
            n_fault = 0;
            done    = 1'b0;
            for (int c = 0; c < 400 && !done; c++) begin
                @(negedge clk);
                if (lsu_stall) n_stall++;
                if (fault) n_fault++;
                if (bus_req) begin
                    chk($sformatf("v%0d_we", idx), 32'(bus_we), 32'(v.wr));
                    chk($sformatf("v%0d_addr", idx), bus_addr, {v.addr[31:2], 2'b00});
                    chk($sformatf("v%0d_be", idx), 32'(bus_be), 32'(v.be));
                    if (v.wr) chk($sformatf("v%0d_wdata", idx), bus_wdata, v.bwd);
                    if (n_req == v.waits) begin
                        bus_ack   = 1'b1;
                        bus_rdata = v.brd;
                    end
                    n_req++;
                end else if (c > 0) begin
                    done = 1'b1;
                    chk($sformatf("v%0d_rdata", idx), rdata, v.rdata);
                    chk($sformatf("v%0d_done_stall", idx), 32'(lsu_stall), 32'd0);
                end
                next_cycle();
                bus_ack   = 1'b0;
                bus_rdata = 32'hFFFF_FFFF;
                if (n_req > 0) begin
                    addr  = ~v.addr;
                    wdata = ~v.wd;
                end
            end
            mem_read  = 1'b0;
            mem_write = 1'b0;
            chk($sformatf("v%0d_completed", idx), 32'(done), 32'd1);
            chk($sformatf("v%0d_stall_cycles", idx), 32'(n_stall), 32'(v.waits + 2));
            chk($sformatf("v%0d_req_cycles", idx), 32'(n_req), 32'(v.waits + 1));
            chk($sformatf("v%0d_no_fault", idx), 32'(n_fault), 32'd0);
        end
    endtask

    initial begin
        int   n_req;
        bit   seen;
        vec_t fresh;

        tbl[0]  = '{1'b1, 1'b0, 3'd4, 32'h103, 32'h0, 32'h80AABBCC, 0, 1'b0, 4'hF, 32'h0, 32'h00000080};
        tbl[1]  = '{1'b1, 1'b0, 3'd1, 32'h102, 32'h0, 32'h8001FFFF, 3, 1'b0, 4'hF, 32'h0, 32'hFFFF8001};
        tbl[2]  = '{1'b0, 1'b1, 3'd0, 32'h201, 32'h123456A5, 32'hFFFFFFFF, 0, 1'b0, 4'b0010, 32'hA5A5A5A5, 32'h0};
        tbl[3]  = '{1'b1, 1'b0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 1, 1'b0, 4'hF, 32'h0, 32'hDEADBEEF};
        tbl[4]  = '{1'b1, 1'b0, 3'd0, 32'h101, 32'h0, 32'h1234F678, 2, 1'b0, 4'hF, 32'h0, 32'hFFFFFFF6};
        tbl[5]  = '{1'b1, 1'b0, 3'd0, 32'h100, 32'h0, 32'h1234F678, 0, 1'b0, 4'hF, 32'h0, 32'h00000078};
        tbl[6]  = '{1'b1, 1'b0, 3'd5, 32'h102, 32'h0, 32'h8001FFFF, 0, 1'b0, 4'hF, 32'h0, 32'h00008001};
        tbl[7]  = '{1'b1, 1'b0, 3'd5, 32'h100, 32'h0, 32'h8001FFFF, 0, 1'b0, 4'hF, 32'h0, 32'h0000FFFF};
        tbl[8]  = '{1'b0, 1'b1, 3'd1, 32'h302, 32'hAAAA1234, 32'hFFFFFFFF, 1, 1'b0, 4'b1100, 32'h12341234, 32'h0};
        tbl[9]  = '{1'b0, 1'b1, 3'd2, 32'h404, 32'hCAFEF00D, 32'hFFFFFFFF, 0, 1'b0, 4'hF, 32'hCAFEF00D, 32'h0};
        tbl[10] = '{1'b1, 1'b1, 3'd0, 32'h003, 32'h0000005A, 32'hFFFFFFFF, 0, 1'b0, 4'b1000, 32'h5A5A5A5A, 32'h0};
        tbl[11] = '{1'b1, 1'b0, 3'd2, 32'h102, 32'h0, 32'h0, 0, 1'b1, 4'h0, 32'h0, 32'h0};
        tbl[12] = '{1'b0, 1'b1, 3'd3, 32'h100, 32'h0, 32'h0, 0, 1'b1, 4'h0, 32'h0, 32'h0};
        tbl[13] = '{1'b1, 1'b0, 3'd1, 32'h101, 32'h0, 32'h0, 0, 1'b1, 4'h0, 32'h0, 32'h0};
        tbl[14] = '{1'b1, 1'b0, 3'd6, 32'h000, 32'h0, 32'h0, 0, 1'b1, 4'h0, 32'h0, 32'h0};
        tbl[15] = '{1'b0, 1'b1, 3'd1, 32'h103, 32'h0, 32'h0, 0, 1'b1, 4'h0, 32'h0, 32'h0};

        #3;
        chk("reset_rdata", rdata, 32'd0);
        chk("reset_req", 32'(bus_req), 32'd0);
        chk("reset_we", 32'(bus_we), 32'd0);
        chk("reset_addr", bus_addr, 32'd0);
        chk("reset_be", 32'(bus_be), 32'd0);
        chk("reset_wdata", bus_wdata, 32'd0);
        chk("reset_fault", 32'(fault), 32'd0);
        chk("reset_stall", 32'(lsu_stall), 32'd0);
        #9 rst = 1'b1;
        next_cycle();

        // Stray ack while idle must be ignored.
        bus_ack   = 1'b1;
        bus_rdata = 32'h12345678;
        next_cycle();
        bus_ack = 1'b0;
        @(negedge clk);
        chk("stray_ack_req", 32'(bus_req), 32'd0);
        chk("stray_ack_stall", 32'(lsu_stall), 32'd0);
        chk("stray_ack_rdata", rdata, 32'd0);
        next_cycle();

        for (int i = 0; i < 16; i++) begin
            run_access(tbl[i], i);
        end

        // Asynchronous reset in the second REQ cycle abandons the access.
        mem_read = 1'b1;
        funct3   = 3'd2;
        addr     = 32'h500;
        next_cycle();
        @(negedge clk);
        chk("rstreq_req1", 32'(bus_req), 32'd1);
        next_cycle();
        #1 rst = 1'b0;
        #1;
        chk("rstreq_req", 32'(bus_req), 32'd0);
        chk("rstreq_stall", 32'(lsu_stall), 32'd0);
        chk("rstreq_addr", bus_addr, 32'd0);
        chk("rstreq_be", 32'(bus_be), 32'd0);
        chk("rstreq_fault", 32'(fault), 32'd0);
        bus_ack   = 1'b1;
        bus_rdata = 32'hAAAA5555;
        mem_read  = 1'b0;
        next_cycle();
        bus_ack = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
        chk("rstreq_late_ack_req", 32'(bus_req), 32'd0);
        chk("rstreq_late_ack_rdata", rdata, 32'd0);
        next_cycle();
        fresh = '{1'b1, 1'b0, 3'd2, 32'h508, 32'h0, 32'h0BADCAFE, 1, 1'b0, 4'hF, 32'h0, 32'h0BADCAFE};
        run_access(fresh, 99);

`ifdef LSU_TIMEOUT_EN
        // Unanswered load times out after four REQ cycles.
        mem_read = 1'b1;
        funct3   = 3'd2;
        addr     = 32'h600;
        n_req    = 0;
        seen     = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (bus_req) begin
                n_req++;
            end else if (c > 0) begin
                seen = 1'b1;
                chk("to_fault", 32'(fault), 32'd1);
                chk("to_rdata", rdata, 32'd0);
                chk("to_stall", 32'(lsu_stall), 32'd0);
            end
            next_cycle();
        end
        mem_read = 1'b0;
        chk("to_reached", 32'(seen), 32'd1);
        chk("to_req_cycles", 32'(n_req), 32'd4);
        bus_ack   = 1'b1;
        bus_rdata = 32'h00001234;
        @(negedge clk);
        chk("to_fault_pulse", 32'(fault), 32'd0);
        chk("to_late_req", 32'(bus_req), 32'd0);
        next_cycle();
        bus_ack = 1'b0;
        @(negedge clk);
        chk("to_late_rdata", rdata, 32'd0);
        chk("to_late_stall", 32'(lsu_stall), 32'd0);
        next_cycle();
`else
        // Without the timeout the request waits indefinitely.
        mem_read = 1'b1;
        funct3   = 3'd2;
        addr     = 32'h700;
        n_req    = 0;
        seen     = 1'b0;
        for (int c = 0; c < 301; c++) begin
            @(negedge clk);
            if (bus_req) n_req++;
            if (fault) seen = 1'b1;
            next_cycle();
        end
        chk("wait_req_cycles", 32'(n_req), 32'd300);
        chk("wait_no_fault", 32'(seen), 32'd0);
        @(negedge clk);
        bus_ack   = 1'b1;
        bus_rdata = 32'h76543210;
        next_cycle();
        bus_ack  = 1'b0;
        mem_read = 1'b0;
        @(negedge clk);
        chk("wait_rdata", rdata, 32'h76543210);
        chk("wait_stall", 32'(lsu_stall), 32'd0);
        next_cycle();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
